// File: rtl/nano_cache_pkg.sv
// nano_cache_pkg
//   Shared types for the NanoCore miss/refill engine: line geometry, the
//   refill FSM state encoding and the beat address helper.
package nano_cache_pkg;

    localparam int LINE_WORDS = 8;
    localparam int WORD_W     = 32;
    localparam int LIDX_W     = 27;

    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_DRAIN = 3'd2,
        ST_WR       = 3'd3,
        ST_DONE     = 3'd4
    } refill_state_t;

    // Byte address of one word beat; the line base is 32-byte aligned, so the
    // beat index never carries past bit 4.
    function automatic logic [31:0] beat_addr(input logic [LIDX_W-1:0] lidx,
                                              input logic [2:0]        beat);
        return {lidx, beat, 2'b00};
    endfunction

endpackage

// File: rtl/nano_refill_wb_buf.sv
// nano_refill_wb_buf
//   One-entry write-back buffer (line index + 8x32b line) used when
//   NANO_REFILL_WB_BUF_EN is defined. Lets a background write-back be accepted
//   while the refill engine is busy; the engine drains it from IDLE ahead of
//   any miss operation.
// Ports
//   clk_i, rst_i   clock, synchronous active-high reset
//   wr_i           write-back request pulse
//   idle_i         refill FSM is in IDLE (a full buffer drains this edge)
//   drain_i        refill FSM takes the buffered line this edge
//   lidx_i/line_i  line index / data of the incoming write-back
//   gnt_o          write-back accepted (combinational)
//   valid_o        buffer holds a line
//   lidx_o/line_o  buffered line index / data
module nano_refill_wb_buf
    import nano_cache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_i,
    input  logic              idle_i,
    input  logic              drain_i,
    input  logic [LIDX_W-1:0] lidx_i,
    input  line_t             line_i,
    output logic              gnt_o,
    output logic              valid_o,
    output logic [LIDX_W-1:0] lidx_o,
    output line_t             line_o
);

    logic              valid_q;
    logic [LIDX_W-1:0] lidx_q;
    line_t             line_q;

    // A full buffer is always drained by an IDLE engine, so it can refill on
    // that same edge.
    assign gnt_o   = wr_i & (~valid_q | idle_i);
    assign valid_o = valid_q;
    assign lidx_o  = lidx_q;
    assign line_o  = line_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
        end else if (gnt_o) begin
            valid_q <= 1'b1;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt_o) begin
            lidx_q <= lidx_i;
            line_q <= line_i;
        end
    end

endmodule

// File: rtl/nano_cache_refill.sv
// nano_cache_refill
//   Miss/refill engine behind the NanoCore cache search stage. Turns read
//   misses, dirty evictions and background write-backs of 8x32b lines into
//   8-beat word bursts on a 32-bit SRAM port and returns refilled lines.
//   Optional feature macro: NANO_REFILL_WB_BUF_EN adds a one-entry
//   write-back buffer (nano_refill_wb_buf).
// Ports
//   i_clk, i_rst                clock, synchronous active-high reset
//   i_miss_rden / i_miss_wren   read-miss / eviction levels, held until o_miss_resp
//   i_wb_wren, o_wb_gnt         background write-back pulse and its same-cycle grant
//   i_miss_addr, i_miss_wdata   line index [26:0] and line data of the request
//   o_miss_resp                 pulse when a miss read or eviction completes
//   o_upd_valid, o_upd_rdata    refilled line (read misses only)
//   o_mem_*                     SRAM request: req, we, byte addr, wdata, wstrb
//   i_mem_gnt                   beat accepted when o_mem_req & i_mem_gnt
//   i_mem_rvalid, i_mem_rdata   in-order read return
//   o_busy                      FSM not IDLE
module nano_cache_refill
    import nano_cache_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_miss_rden,
    input  logic        i_miss_wren,
    input  logic        i_wb_wren,
    input  logic [31:0] i_miss_addr,
    input  line_t       i_miss_wdata,
    output logic        o_miss_resp,
    output logic        o_wb_gnt,
    output logic        o_upd_valid,
    output line_t       o_upd_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_busy
);

    localparam logic [3:0] OUTST_LIM = 4'(MAX_OUTST);

    refill_state_t     state_q;
    logic [2:0]        issue_q;
    logic [2:0]        ret_q;
    logic [3:0]        outst_q;
    logic              miss_op_q;
    logic              resp_q;
    logic              upd_q;
    logic [LIDX_W-1:0] lidx_q;
    line_t             line_q;

    logic              is_idle;
    logic              start_rd;
    logic              start_wr;
    logic              start_miss;
    logic [LIDX_W-1:0] src_lidx;
    line_t             src_line;
    logic              rd_issue;
    logic              beat_fire;
    logic              rd_fire;
    logic              ret_en;
    logic              unused_addr_hi;

    assign is_idle        = (state_q == ST_IDLE);
    assign unused_addr_hi = ^i_miss_addr[31:LIDX_W];

`ifdef NANO_REFILL_WB_BUF_EN
    logic              buf_valid;
    logic              sel_buf;
    logic [LIDX_W-1:0] buf_lidx;
    line_t             buf_line;

    // Buffered write-back wins in IDLE, so a later read of that line sees it.
    assign sel_buf = is_idle & buf_valid;

    nano_refill_wb_buf u_wb_buf (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .wr_i    (i_wb_wren),
        .idle_i  (is_idle),
        .drain_i (sel_buf),
        .lidx_i  (i_miss_addr[LIDX_W-1:0]),
        .line_i  (i_miss_wdata),
        .gnt_o   (o_wb_gnt),
        .valid_o (buf_valid),
        .lidx_o  (buf_lidx),
        .line_o  (buf_line)
    );

    assign src_lidx = sel_buf ? buf_lidx : i_miss_addr[LIDX_W-1:0];
    assign src_line = sel_buf ? buf_line : i_miss_wdata;
`else
    assign o_wb_gnt = i_wb_wren & is_idle & ~i_miss_rden & ~i_miss_wren;
    assign src_lidx = i_miss_addr[LIDX_W-1:0];
    assign src_line = i_miss_wdata;
`endif

    // Request arbitration in IDLE: buffered wb > eviction > read miss > wb.
    always_comb begin
        start_rd   = 1'b0;
        start_wr   = 1'b0;
        start_miss = 1'b0;
        if (is_idle) begin
`ifdef NANO_REFILL_WB_BUF_EN
            if (buf_valid) begin
                start_wr = 1'b1;
            end else
`endif
            if (i_miss_wren) begin
                start_wr   = 1'b1;
                start_miss = 1'b1;
            end else if (i_miss_rden) begin
                start_rd   = 1'b1;
                start_miss = 1'b1;
            end
`ifndef NANO_REFILL_WB_BUF_EN
            else if (i_wb_wren) begin
                start_wr = 1'b1;
            end
`endif
        end
    end

    // Read issue holds off (address stays put) while the return window is full.
    assign rd_issue  = (state_q == ST_RD) && (outst_q != OUTST_LIM);
    assign o_mem_req = rd_issue | (state_q == ST_WR);
    assign o_mem_we  = (state_q == ST_WR);
    assign beat_fire = o_mem_req & i_mem_gnt;
    assign rd_fire   = beat_fire & ~o_mem_we;
    assign ret_en    = i_mem_rvalid & ((state_q == ST_RD) | (state_q == ST_RD_DRAIN));

    assign o_mem_addr  = o_mem_req ? beat_addr(lidx_q, issue_q) : 32'd0;
    assign o_mem_wdata = o_mem_we ? line_q[issue_q] : 32'd0;
    assign o_mem_wstrb = o_mem_we ? 4'hF : 4'h0;
    assign o_miss_resp = resp_q;
    assign o_upd_valid = upd_q;
    assign o_upd_rdata = upd_q ? line_q : '0;
    assign o_busy      = ~is_idle;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            issue_q   <= 3'd0;
            ret_q     <= 3'd0;
            outst_q   <= 4'd0;
            miss_op_q <= 1'b0;
            resp_q    <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            upd_q  <= 1'b0;

            case ({rd_fire, ret_en})
                2'b10:   outst_q <= outst_q + 4'd1;
                2'b01:   outst_q <= outst_q - 4'd1;
                default: ;
            endcase

            if (ret_en) begin
                ret_q <= ret_q + 3'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    issue_q   <= 3'd0;
                    ret_q     <= 3'd0;
                    miss_op_q <= start_miss;
                    if (start_rd) begin
                        state_q <= ST_RD;
                    end else if (start_wr) begin
                        state_q <= ST_WR;
                    end
                end
                ST_RD: begin
                    if (rd_fire) begin
                        issue_q <= issue_q + 3'd1;
                        if (issue_q == 3'd7) begin
                            state_q <= ST_RD_DRAIN;
                        end
                    end
                end
                ST_RD_DRAIN: begin
                    if (ret_en && ret_q == 3'd7) begin
                        state_q <= ST_DONE;
                        resp_q  <= 1'b1;
                        upd_q   <= 1'b1;
                    end
                end
                ST_WR: begin
                    if (beat_fire) begin
                        issue_q <= issue_q + 3'd1;
                        if (issue_q == 3'd7) begin
                            state_q <= ST_DONE;
                            resp_q  <= miss_op_q;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Line register: loaded with the request, then filled word by word on returns.
    always_ff @(posedge i_clk) begin
        if (start_rd | start_wr) begin
            lidx_q <= src_lidx;
            line_q <= src_line;
        end else if (ret_en) begin
            line_q[ret_q] <= i_mem_rdata;
        end
    end

endmodule

// File: tb/tb_nano_cache_refill.sv
module tb_nano_cache_refill;
    import nano_cache_pkg::*;

    localparam int MAXO = 2;
`ifdef NANO_REFILL_WB_BUF_EN
    localparam logic BUSY_WB_GNT = 1'b1;
`else
    localparam logic BUSY_WB_GNT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss_rden, i_miss_wren, i_wb_wren;
    logic [31:0] i_miss_addr;
    line_t       i_miss_wdata;
    logic        o_miss_resp, o_wb_gnt, o_upd_valid;
    line_t       o_upd_rdata;
    logic        o_mem_req, o_mem_we;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wstrb;
    logic        i_mem_gnt, i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_busy;

    nano_cache_refill #(.MAX_OUTST(MAXO)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_miss_rden  (i_miss_rden),
        .i_miss_wren  (i_miss_wren),
        .i_wb_wren    (i_wb_wren),
        .i_miss_addr  (i_miss_addr),
        .i_miss_wdata (i_miss_wdata),
        .o_miss_resp  (o_miss_resp),
        .o_wb_gnt     (o_wb_gnt),
        .o_upd_valid  (o_upd_valid),
        .o_upd_rdata  (o_upd_rdata),
        .o_mem_req    (o_mem_req),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .o_mem_wstrb  (o_mem_wstrb),
        .i_mem_gnt    (i_mem_gnt),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } beat_t;
    typedef struct { logic upd; line_t rdata; int due; } done_t;
    typedef struct { int due; logic [31:0] addr; } rd_t;

    beat_t       exp_beat_q[$];
    done_t       exp_done_q[$];
    rd_t         rdq[$];
    logic [31:0] mem [logic [31:0]];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   lat = 1;
    int   outst = 0;
    logic gmode = 1'b0;
    logic tog = 1'b1;

    assign i_mem_gnt = gmode ? tog : 1'b1;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hDEAD0000 | a;
    endfunction

    // SRAM model: gnt pattern, in-order read return after `lat` cycles, shares reset.
    logic        m_acc;
    logic [31:0] m_addr;
    always begin
        @(negedge clk);
        m_acc  = 1'b0;
        m_addr = 32'd0;
        if (rst) begin
            rdq.delete();
            i_mem_rvalid = 1'b0;
        end else if (o_mem_req && i_mem_gnt) begin
            if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
            else begin
                m_acc  = 1'b1;
                m_addr = o_mem_addr;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        tog = ~tog;
        if (m_acc) rdq.push_back('{due: cyc - 1 + lat, addr: m_addr});
        if (rdq.size() != 0 && rdq[0].due == cyc) begin
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = rd_word(rdq[0].addr);
            void'(rdq.pop_front());
        end else begin
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = 32'd0;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a beat or a completion.
    logic        prev_stall = 1'b0;
    logic        prev_we;
    logic [31:0] prev_addr;
    beat_t       mb;
    done_t       md;
    always begin
        @(negedge clk);
        if (rst) begin
            outst      = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("addr_hold", 256'({o_mem_req, o_mem_we, o_mem_addr}),
                    256'({1'b1, prev_we, prev_addr}));
            prev_stall = o_mem_req & ~i_mem_gnt;
            prev_we    = o_mem_we;
            prev_addr  = o_mem_addr;
            if (o_mem_req && i_mem_gnt) begin
                chk("beat_expected", 256'(exp_beat_q.size() != 0), 256'(1));
                if (!o_mem_we) begin
                    chk("outst_limit", 256'(outst < MAXO), 256'(1));
                    outst++;
                end
                if (exp_beat_q.size() != 0) begin
                    mb = exp_beat_q.pop_front();
                    chk("beat_we_addr", 256'({o_mem_we, o_mem_addr}), 256'({mb.we, mb.addr}));
                    if (mb.we) begin
                        chk("beat_wdata", 256'(o_mem_wdata), 256'(mb.wdata));
                        chk("beat_wstrb", 256'(o_mem_wstrb), 256'(4'hF));
                    end
                end
            end
            if (i_mem_rvalid) outst--;
            if (o_miss_resp || o_upd_valid) begin
                chk("done_expected", 256'(exp_done_q.size() != 0), 256'(1));
                if (exp_done_q.size() != 0) begin
                    md = exp_done_q.pop_front();
                    chk("done_flags", 256'({o_miss_resp, o_upd_valid}), 256'({1'b1, md.upd}));
                    chk("done_rdata", o_upd_rdata, md.rdata);
                    if (md.due != 0) chk("done_cycle", 256'(cyc), 256'(md.due));
                end
            end
        end
    end

    task automatic push_beats(input logic we, input logic [31:0] lidx, input line_t d);
        for (int i = 0; i < 8; i++)
            exp_beat_q.push_back('{we: we, addr: {lidx[26:0], 5'b0} + 32'(4 * i), wdata: d[i]});
    endtask

    function automatic line_t mk_line(input logic [31:0] base);
        line_t l;
        for (int i = 0; i < 8; i++) l[i] = base + 32'(i);
        return l;
    endfunction

    task automatic preload(input logic [31:0] baddr, input logic [31:0] base);
        for (int i = 0; i < 8; i++) mem[baddr + 32'(4 * i)] = base + 32'(i);
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_miss_resp && n < 200);
        chk(name, 256'(o_miss_resp), 256'(1));
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((o_busy || exp_beat_q.size() != 0 || exp_done_q.size() != 0) && n < 300);
        chk("idle_busy", 256'(o_busy), 256'(0));
        chk("idle_beats_left", 256'(exp_beat_q.size()), 256'(0));
        chk("idle_done_left", 256'(exp_done_q.size()), 256'(0));
    endtask

    // Called at a negedge; pulse lasts exactly one rising edge.
    task automatic wb_pulse(input logic [31:0] lidx, input line_t d, input logic exp_gnt);
        i_wb_wren    = 1'b1;
        i_miss_addr  = lidx;
        i_miss_wdata = d;
        #1;
        chk("wb_gnt", 256'(o_wb_gnt), 256'(exp_gnt));
        if (exp_gnt) push_beats(1'b1, lidx, d);
        @(negedge clk);
        i_wb_wren = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        chk(name, 256'({o_miss_resp, o_wb_gnt, o_upd_valid, o_mem_req, o_mem_we, o_busy}), 256'(0));
        chk("quiet_mem_addr_wdata", 256'({o_mem_addr, o_mem_wdata, o_mem_wstrb}), 256'(0));
        chk("quiet_upd_rdata", o_upd_rdata, 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        i_miss_rden  = 1'b0;
        i_miss_wren  = 1'b0;
        i_wb_wren    = 1'b0;
        i_miss_addr  = 32'd0;
        i_miss_wdata = '0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata  = 32'd0;
        repeat (3) @(negedge clk);
        check_quiet("reset_outputs");
        rst = 1'b0;
        @(negedge clk);

        // 1: read miss line 0x40, latency 1, done exactly at cycle 10
        preload(32'h800, 32'hA0);
        push_beats(1'b0, 32'h40, '0);
        exp_done_q.push_back('{upd: 1'b1, rdata: mk_line(32'hA0), due: cyc + 10});
        i_miss_addr = 32'h40;
        i_miss_rden = 1'b1;
        wait_resp("t1_resp");
        i_miss_rden = 1'b0;
        wait_idle();

        // 2: eviction of line 0x1234, data word i = i
        push_beats(1'b1, 32'h1234, mk_line(32'd0));
        exp_done_q.push_back('{upd: 1'b0, rdata: '0, due: cyc + 9});
        i_miss_addr  = 32'h1234;
        i_miss_wdata = mk_line(32'd0);
        i_miss_wren  = 1'b1;
        wait_resp("t2_resp");
        i_miss_wren = 1'b0;
        wait_idle();

        // 3: toggling grant, latency 3, MAX_OUTST 2
        gmode = 1'b1;
        lat   = 3;
        preload(32'h400, 32'hC0);
        push_beats(1'b0, 32'h20, '0);
        exp_done_q.push_back('{upd: 1'b1, rdata: mk_line(32'hC0), due: 0});
        i_miss_addr = 32'h20;
        i_miss_rden = 1'b1;
        wait_resp("t3_resp");
        i_miss_rden = 1'b0;
        wait_idle();
        gmode = 1'b0;
        lat   = 1;

        // 4a: background write-back from IDLE, no completion pulse
        wb_pulse(32'h77, mk_line(32'h7700), 1'b1);
        wait_idle();

        // 4b: write-back during a read miss
        preload(32'h820, 32'hB0);
        push_beats(1'b0, 32'h41, '0);
        exp_done_q.push_back('{upd: 1'b1, rdata: mk_line(32'hB0), due: 0});
        i_miss_addr = 32'h41;
        i_miss_rden = 1'b1;
        repeat (3) @(negedge clk);
        wb_pulse(32'h66, mk_line(32'h6600), BUSY_WB_GNT);
        wait_resp("t4_resp");
        i_miss_rden = 1'b0;
        wait_idle();

`ifdef NANO_REFILL_WB_BUF_EN
        // 5: buffered write-back of line 0x55 drains before a read of that line
        preload(32'hAA0, 32'hEEEE0000);
        push_beats(1'b1, 32'h99, mk_line(32'h9900));
        exp_done_q.push_back('{upd: 1'b0, rdata: '0, due: 0});
        i_miss_addr  = 32'h99;
        i_miss_wdata = mk_line(32'h9900);
        i_miss_wren  = 1'b1;
        repeat (2) @(negedge clk);
        wb_pulse(32'h55, mk_line(32'h5500), 1'b1);
        push_beats(1'b0, 32'h55, '0);
        exp_done_q.push_back('{upd: 1'b1, rdata: mk_line(32'h5500), due: 0});
        wait_resp("t5_evict_resp");
        i_miss_wren = 1'b0;
        i_miss_addr = 32'h55;
        i_miss_rden = 1'b1;
        wait_resp("t5_read_resp");
        i_miss_rden = 1'b0;
        wait_idle();
`endif

        // 6: reset during read beat 4, then a clean read of line 0x10
        push_beats(1'b0, 32'h30, '0);
        i_miss_addr = 32'h30;
        i_miss_rden = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst         = 1'b1;
        i_miss_rden = 1'b0;
        @(negedge clk);
        check_quiet("t6_after_reset");
        exp_beat_q.delete();
        #2;
        rst = 1'b0;
        @(negedge clk);
        preload(32'h200, 32'h1000);
        push_beats(1'b0, 32'h10, '0);
        exp_done_q.push_back('{upd: 1'b1, rdata: mk_line(32'h1000), due: cyc + 10});
        i_miss_addr = 32'h10;
        i_miss_rden = 1'b1;
        wait_resp("t6_resp");
        i_miss_rden = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
